// File: rtl/dino_pkg.sv
// Shared types and constants for the dino game path (motion controller and VGA side).
package dino_pkg;

    typedef enum logic [2:0] {
        READY = 3'd0,
        RUN   = 3'd1,
        DUCK  = 3'd2,
        RISE  = 3'd3,
        FALL  = 3'd4,
        DEAD  = 3'd5
    } state_t;

    localparam logic [1:0] ANIM_LEG0 = 2'd0;
    localparam logic [1:0] ANIM_LEG1 = 2'd1;
    localparam logic [1:0] ANIM_AIR  = 2'd2;
    localparam logic [1:0] ANIM_DUCK = 2'd3;

    // Ground line 335 minus the 60-px sprite height.
    localparam int GROUND_Y = 275;

    localparam int JUMP_V0     = 12;
    localparam int GRAVITY     = 1;
    localparam int MAX_FALL    = 15;
    localparam int ANIM_PERIOD = 6;
    localparam int SCORE_DIV   = 4;

endpackage

// File: rtl/dino_input_sync.sv
// Button synchronizers and a one-shot frame edge, so each frame advances the game once
// no matter how long the screen-end pulse stays high.
module dino_input_sync (
    input  logic clk,
    input  logic reset,
    input  logic frame_tick,
    input  logic btn_jump,
    input  logic btn_duck,
    output logic jump_s,
    output logic duck_s,
    output logic frame_edge
);

    logic [1:0] jump_ff;
    logic [1:0] duck_ff;
    logic       ft_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            jump_ff <= 2'b00;
            duck_ff <= 2'b00;
            ft_q    <= 1'b0;
        end else begin
            jump_ff <= {jump_ff[0], btn_jump};
            duck_ff <= {duck_ff[0], btn_duck};
            ft_q    <= frame_tick;
        end
    end

    assign jump_s     = jump_ff[1];
    assign duck_s     = duck_ff[1];
    assign frame_edge = frame_tick & ~ft_q;

endmodule

// File: rtl/dino_motion_controller.sv
// Per-frame dino sequencer: position, jump physics, animation select, score and game-over.
module dino_motion_controller
    import dino_pkg::*;
#(
    parameter int GROUND_Y_P  = dino_pkg::GROUND_Y,
    parameter int JUMP_V0     = dino_pkg::JUMP_V0,
    parameter int GRAVITY     = dino_pkg::GRAVITY,
    parameter int MAX_FALL    = dino_pkg::MAX_FALL,
    parameter int ANIM_PERIOD = dino_pkg::ANIM_PERIOD,
    parameter int SCORE_DIV   = dino_pkg::SCORE_DIV
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        frame_tick,
    input  logic        btn_jump,
    input  logic        btn_duck,
    input  logic        collision,
    output logic [9:0]  dino_y,
    output logic [1:0]  anim_sel,
    output logic [2:0]  state,
    output logic [15:0] score,
    output logic [15:0] hi_score,
    output logic        game_over
);

    localparam logic [9:0] GY         = 10'(GROUND_Y_P);
    localparam logic [9:0] START_Y    = 10'(GROUND_Y_P - JUMP_V0);
    localparam logic [4:0] START_V    = 5'(JUMP_V0 - GRAVITY);
    localparam logic [4:0] GRAV       = 5'(GRAVITY);
    localparam logic [5:0] VMAX       = 6'(MAX_FALL);
    localparam logic [7:0] ANIM_LAST  = 8'(ANIM_PERIOD - 1);
    localparam logic [7:0] SCORE_LAST = 8'(SCORE_DIV - 1);

    logic jump_s, duck_s, frame_edge;

    dino_input_sync u_sync (
        .clk        (clk),
        .reset      (reset),
        .frame_tick (frame_tick),
        .btn_jump   (btn_jump),
        .btn_duck   (btn_duck),
        .jump_s     (jump_s),
        .duck_s     (duck_s),
        .frame_edge (frame_edge)
    );

    state_t     st;
    logic [4:0] velocity;
    logic [7:0] anim_cnt;
    logic [7:0] score_cnt;
    logic       leg;
    logic       col_lat;

    logic [5:0]  v_sum;
    logic [4:0]  fall_v;
    logic [10:0] fall_y;
    logic        land;
    logic [9:0]  rise_y;
    logic        rise_done;
    logic        in_play;
    logic        hit;

    // Fall step with the speed cap applied before the landing test.
    assign v_sum     = {1'b0, velocity} + {1'b0, GRAV};
    assign fall_v    = (v_sum > VMAX) ? VMAX[4:0] : v_sum[4:0];
    assign fall_y    = {1'b0, dino_y} + {6'd0, fall_v};
    assign land      = fall_y >= {1'b0, GY};
    assign rise_y    = dino_y - {5'd0, velocity};
    assign rise_done = velocity <= GRAV;
    assign in_play   = (st == RUN) || (st == DUCK) || (st == RISE) || (st == FALL);
    // A collision on the edge cycle itself still counts for this frame.
    assign hit       = col_lat | collision;

    assign state = st;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            st        <= READY;
            dino_y    <= GY;
            velocity  <= 5'd0;
            anim_sel  <= ANIM_LEG0;
            score     <= 16'd0;
            hi_score  <= 16'd0;
            game_over <= 1'b0;
            anim_cnt  <= 8'd0;
            score_cnt <= 8'd0;
            leg       <= 1'b0;
            col_lat   <= 1'b0;
        end else begin
            if (collision)
                col_lat <= 1'b1;
            if (frame_edge) begin
                col_lat <= 1'b0;
                if (in_play && hit) begin
                    st        <= DEAD;
                    game_over <= 1'b1;
                    if (score > hi_score)
                        hi_score <= score;
                end else begin
                    if (in_play) begin
                        if (score_cnt == SCORE_LAST) begin
                            score_cnt <= 8'd0;
                            if (score != 16'hFFFF)
                                score <= score + 16'd1;
                        end else begin
                            score_cnt <= score_cnt + 8'd1;
                        end
                    end
                    case (st)
                        READY: begin
                            anim_sel <= ANIM_LEG0;
                            if (jump_s) begin
                                score    <= 16'd0;
                                dino_y   <= START_Y;
                                velocity <= START_V;
                                anim_sel <= ANIM_AIR;
                                st       <= RISE;
                            end
                        end
                        RUN: begin
                            if (jump_s) begin
                                dino_y   <= START_Y;
                                velocity <= START_V;
                                anim_sel <= ANIM_AIR;
                                st       <= RISE;
                            end else if (duck_s) begin
                                anim_sel <= ANIM_DUCK;
                                st       <= DUCK;
                            end else if (anim_cnt == ANIM_LAST) begin
                                anim_cnt <= 8'd0;
                                leg      <= ~leg;
                                anim_sel <= {1'b0, ~leg};
                            end else begin
                                anim_cnt <= anim_cnt + 8'd1;
                                anim_sel <= {1'b0, leg};
                            end
                        end
                        DUCK: begin
                            if (!duck_s) begin
                                anim_sel <= {1'b0, leg};
                                st       <= RUN;
                            end
                        end
                        RISE: begin
                            dino_y <= rise_y;
                            if (rise_done) begin
                                velocity <= 5'd0;
                                st       <= FALL;
                            end else begin
                                velocity <= velocity - GRAV;
                            end
                        end
                        FALL: begin
                            if (land) begin
                                dino_y   <= GY;
                                velocity <= 5'd0;
                                if (duck_s) begin
                                    anim_sel <= ANIM_DUCK;
                                    st       <= DUCK;
                                end else begin
                                    anim_sel <= {1'b0, leg};
                                    st       <= RUN;
                                end
                            end else begin
                                dino_y   <= fall_y[9:0];
                                velocity <= fall_v;
                            end
                        end
                        DEAD: begin
                            // Score stays visible until the next game start.
                            if (jump_s) begin
                                dino_y    <= GY;
                                velocity  <= 5'd0;
                                anim_cnt  <= 8'd0;
                                score_cnt <= 8'd0;
                                leg       <= 1'b0;
                                anim_sel  <= ANIM_LEG0;
                                game_over <= 1'b0;
                                st        <= READY;
                            end
                        end
                        default: st <= READY;
                    endcase
                end
            end
        end
    end

endmodule
